// File: rtl/bcd_updown_counter_multi.sv
// rtl/bcd_updown_counter_multi.sv - multi-decade BCD up/down counter with load, wrap/saturate and event flags
// All decades step in one cycle through a combinational carry/borrow chain.
module bcd_updown_counter_multi #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  updown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap_evt,
  output logic                  sat,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap_evt;
  logic                r_sat;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_next;
  logic [DIGITS:0]     w_carry;
  logic                w_all9;
  logic                w_all0;
  logic                w_load_ok;
  logic                w_at_bound;

  // w_carry[i] means digit i steps this cycle; an out-of-range digit is forced to 0.
  always_comb begin
    w_all9    = 1'b1;
    w_all0    = 1'b1;
    w_load_ok = 1'b1;
    w_next    = r_count;
    w_carry   = '0;
    w_carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_count[4*i +: 4] != 4'd9) w_all9 = 1'b0;
      if (r_count[4*i +: 4] != 4'd0) w_all0 = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
      if (r_count[4*i +: 4] > 4'd9) begin
        w_next[4*i +: 4] = 4'd0;
      end else if (w_carry[i]) begin
        if (updown)
          w_next[4*i +: 4] = (r_count[4*i +: 4] == 4'd9) ? 4'd0 : r_count[4*i +: 4] + 4'd1;
        else
          w_next[4*i +: 4] = (r_count[4*i +: 4] == 4'd0) ? 4'd9 : r_count[4*i +: 4] - 4'd1;
      end
      w_carry[i+1] = w_carry[i] &&
                     (updown ? (r_count[4*i +: 4] == 4'd9) : (r_count[4*i +: 4] == 4'd0));
    end
  end

  assign w_at_bound = updown ? w_all9 : w_all0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_wrap_evt <= 1'b0;
      r_sat      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_wrap_evt <= 1'b0;
      if (w_load_ok) begin
        r_count    <= load_val;
        r_sat      <= 1'b0;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
    end else if (en) begin
      r_load_err <= 1'b0;
      if (w_at_bound && !WRAP) begin
        r_sat      <= 1'b1;
        r_wrap_evt <= 1'b0;
      end else begin
        r_count    <= w_next;
        r_sat      <= 1'b0;
        r_wrap_evt <= w_at_bound;
      end
    end else begin
      r_wrap_evt <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = en & w_at_bound;
  assign wrap_evt = r_wrap_evt;
  assign sat      = r_sat;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter_multi.sv
// tb/tb_bcd_updown_counter_multi.sv - directed scoreboard bench for wrap and saturate variants
// Index 0 of the model arrays is the WRAP=1 instance, index 1 the WRAP=0 instance.
module tb_bcd_updown_counter_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        updown;
  logic        load;
  logic [15:0] load_val;

  logic [15:0] cnt_w, cnt_s;
  logic        tc_w, tc_s, wev_w, wev_s, sat_w, sat_s, le_w, le_s;

  always #5 clk = ~clk;

  bcd_updown_counter_multi #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .count(cnt_w), .tc(tc_w), .wrap_evt(wev_w),
    .sat(sat_w), .load_err(le_w)
  );

  bcd_updown_counter_multi #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .count(cnt_s), .tc(tc_s), .wrap_evt(wev_s),
    .sat(sat_s), .load_err(le_s)
  );

  typedef struct packed {
    logic [15:0] cnt;
    logic        wrap;
    logic        sat;
    logic        lerr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_v[2];
  logic m_wrap[2];
  logic m_sat[2];
  logic m_lerr[2];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_wrap[k] = 1'b0; m_sat[k] = 1'b0; m_lerr[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input bit ld, input bit e, input bit up,
                            input logic [15:0] lv);
    bit bound;
    if (ld) begin
      m_wrap[k] = 1'b0;
      if (bcd_ok(lv)) begin
        m_v[k] = from_bcd(lv); m_sat[k] = 1'b0; m_lerr[k] = 1'b0;
      end else begin
        m_lerr[k] = 1'b1;
      end
    end else if (e) begin
      m_lerr[k] = 1'b0;
      bound = up ? (m_v[k] == 9999) : (m_v[k] == 0);
      if (bound && k == 1) begin
        m_sat[k] = 1'b1; m_wrap[k] = 1'b0;
      end else begin
        m_v[k]    = up ? (m_v[k] + 1) % 10000 : (m_v[k] + 9999) % 10000;
        m_wrap[k] = bound;
        m_sat[k]  = 1'b0;
      end
    end else begin
      m_wrap[k] = 1'b0; m_lerr[k] = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cnt_w"}, cnt_w, 16'h0000);
    chk({tag, "_cnt_s"}, cnt_s, 16'h0000);
    chk({tag, "_flags_w"}, {13'd0, wev_w, sat_w, le_w}, 16'h0000);
    chk({tag, "_flags_s"}, {13'd0, wev_s, sat_s, le_s}, 16'h0000);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
        e = q.pop_front();
        if (k == 0) begin
          chk({tag, "_cnt_w"}, cnt_w, e.cnt);
          chk({tag, "_flags_w"}, {13'd0, wev_w, sat_w, le_w}, {13'd0, e.wrap, e.sat, e.lerr});
        end else begin
          chk({tag, "_cnt_s"}, cnt_s, e.cnt);
          chk({tag, "_flags_s"}, {13'd0, wev_s, sat_s, le_s}, {13'd0, e.wrap, e.sat, e.lerr});
        end
      end
    end
  endtask

  task automatic step(input bit e, input bit up, input bit ld, input logic [15:0] lv,
                      input string tag);
    logic tc_exp;
    en = e; updown = up; load = ld; load_val = lv;
    #1;
    tc_exp = e && (up ? (m_v[0] == 9999) : (m_v[0] == 0));
    chk({tag, "_tc_w"}, {15'd0, tc_w}, {15'd0, tc_exp});
    tc_exp = e && (up ? (m_v[1] == 9999) : (m_v[1] == 0));
    chk({tag, "_tc_s"}, {15'd0, tc_s}, {15'd0, tc_exp});
    for (int k = 0; k < 2; k++) begin
      model_edge(k, ld, e, up, lv);
      q.push_back('{cnt: to_bcd(m_v[k]), wrap: m_wrap[k], sat: m_sat[k], lerr: m_lerr[k]});
    end
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; updown = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    #3;
    check_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 999; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, "up_run");
    chk("up_run_end", cnt_w, 16'h0999);

    step(1'b0, 1'b1, 1'b1, 16'h9998, "ld_9998");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "up_9999");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "up_wrap");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "up_after");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "dn_unsat");
    step(1'b0, 1'b0, 1'b0, 16'h0000, "hold");

    step(1'b0, 1'b0, 1'b1, 16'h0100, "ld_0100");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "dn_0099");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "dn_0098");
    step(1'b0, 1'b0, 1'b1, 16'h0000, "ld_0000");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "dn_wrap");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "dn_after");

    step(1'b1, 1'b1, 1'b1, 16'h12A4, "ld_bad");
    step(1'b1, 1'b1, 1'b1, 16'h1234, "ld_1234");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "up_1235");
    step(1'b0, 1'b1, 1'b0, 16'h0000, "err_clear");

    step(1'b0, 1'b1, 1'b1, 16'h4567, "ld_4567");
    step(1'b1, 1'b1, 1'b1, 16'hF000, "ld_bad2");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'h0000, "post_rst");

    step(1'b0, 1'b1, 1'b1, 16'h0005, "ld_0005");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "tog1");
    step(1'b0, 1'b0, 1'b0, 16'h0000, "tog2");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "tog3");
    step(1'b0, 1'b1, 1'b0, 16'h0000, "tog4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_multi.md
Name: bcd_updown_counter_multi

Overview:
- Parametrised multi-digit synchronous BCD up/down counter. Successor to the single-digit 0-9 up/down counter.
- Adds:
  - DIGITS cascaded decades
  - count enable
  - validated parallel load
  - wrap or saturate mode
  - terminal-count and wrap-event outputs
- Used as an event/tally counter feeding BCD display drivers. Cascaded digits update in one cycle, with no ripple clocking.

Parameters:
- DIGITS, 4, number of BCD decades (1-8); count range 0 to 10^DIGITS-1.
- WRAP, 1, 1 = wrap at the boundaries (max->0 up, 0->max down); 0 = hold at the boundary (saturate).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- updown  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel-load request.
- load_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- count  output  4*DIGITS  current BCD count; digit 0 in bits [3:0].
- tc  output  1  combinational terminal count: high when en=1 and the count is at the boundary in the current direction (all 9s when up, all 0s when down). Used for cascading another instance.
- wrap_evt  output  1  registered one-cycle pulse; high in the cycle after a wrap occurred.
- sat  output  1  registered; high while the counter is held at a boundary with WRAP=0.
- load_err  output  1  registered one-cycle pulse; high in the cycle after a rejected load.

Behaviour:
- Reset: reset_n low forces count=0, wrap_evt=0, sat=0, load_err=0 immediately and asynchronously. Release is synchronous to clk; the first update is on the first rising edge with reset_n high.
- Priority each rising edge: load > en > hold.
- Load (load=1):
  - All load_val digits <=9: count<=load_val next edge, load_err<=0, wrap_evt<=0, sat<=0. en is ignored that cycle.
  - Any digit >9: count unchanged, load_err<=1 for one cycle, en ignored.
- Count up (en=1, load=0, updown=1):
  - Digit i increments when all lower digits equal 9. A digit at 9 that increments goes to 0.
  - Digit 0 always steps.
  - The whole count updates in a single cycle.
- Count down (en=1, load=0, updown=0):
  - Digit i decrements when all lower digits equal 0. A digit at 0 that decrements goes to 9.
  - Digit 0 always steps.
- Boundaries, WRAP=1:
  - All 9s, up -> all 0s, wrap_evt<=1.
  - All 0s, down -> all 9s, wrap_evt<=1.
  - sat stays 0.
- Boundaries, WRAP=0:
  - At the boundary the count holds, sat<=1, wrap_evt stays 0.
  - sat clears on any edge where the count changes or a load is accepted.
- Hold (en=0, load=0): count holds; wrap_evt and load_err are 0 next cycle; sat keeps its value.
- Pulse width: wrap_evt and load_err are never high for more than one consecutive cycle unless the triggering condition repeats on consecutive edges.
- Direction change: updown may change on any cycle and takes effect on the next enabled edge. No glitch states.
- Invalid internal codes: unreachable from reset or an accepted load. If one appears, the counter must not remain stuck in invalid codes; any enabled step moves every digit to a valid BCD value.
- Reset mid-operation: overrides load/en in any cycle; no pending pulse survives reset.
- tc: pure combinational function of count, updown and en. It does not depend on WRAP.

Test Plan:
- DIGITS=4, WRAP=1: reset_n low, release; en=1, updown=1 for 1000 cycles -> count 0000,0001..0009,0010..0999; then 9999->0000 with wrap_evt=1 for exactly one cycle; tc=1 only while count=9999.
- Load 0100, then updown=0, en=1 -> 0099, 0098; load 0000 then one down step -> 9999, wrap_evt=1.
- WRAP=0: load 9998, up -> 9999, then 9999 with sat=1 and wrap_evt=0; switch to down -> 9998, sat=0.
- load_val=0x12A4 with load=1 and en=1 -> count unchanged, load_err pulses 1 cycle; next, load 1234 with en=1 -> count=1234 (load wins), then 1235.
- Assert reset_n low asynchronously mid-count at 4567 between clock edges -> count=0000 immediately; sat, wrap_evt and load_err all 0; first edge after release with en=1, up -> 0001.
- en toggling 1,0,1,0 with updown alternating, starting from 0005 -> 0006, 0006, 0005, 0005; tc low throughout.
